addsub_seq: RTL

- Parametrised, multi-cycle two's-complement adder/subtractor: the WIDTH-bit datapath is processed CHUNK bits per clock through one shared ripple segment.
- Optional magnitude mode returns |A-B| plus a sign flag, using a second chunked pass.
- Valid/ready on both input and output, so it sits between an operand source and a result consumer in the ALU datapath.

---
 rtl/addsub_pkg.sv | 22 ++
 rtl/addsub_seq_if.sv | 30 +++
 rtl/addsub_seq_chunk_addsub.sv | 28 ++
 rtl/addsub_seq.sv | 131 +++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the chunked adder/subtractor.
//   state_t  : controller states
//   nchunks  : number of CHUNK-bit segments in a WIDTH-bit operand
//   idx_w    : chunk-index register width (clog2(N), at least 1)
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int nchunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_seq_if.sv
// Operand/result handshake bundle for addsub_seq.
//   in_valid/in_ready  : operand channel (a, b, sub, mag)
//   out_valid/out_ready: result channel (result, cout, ovf, neg)
// master = operand source / result consumer, slave = addsub_seq.
interface addsub_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             mag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             neg;

  modport master (
    output in_valid, a, b, sub, mag, out_ready,
    input  in_ready, out_valid, result, cout, ovf, neg
  );

  modport slave (
    input  in_valid, a, b, sub, mag, out_ready,
    output in_ready, out_valid, result, cout, ovf, neg
  );
endinterface

// File: rtl/addsub_seq_chunk_addsub.sv
// Combinational CHUNK-bit ripple-carry segment.
//   x, y     : chunk operands
//   cin      : carry into bit 0
//   sum      : chunk sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (for signed-overflow detection)
module chunk_addsub #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]  = x[i] ^ y[i] ^ c[i];
    assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract, CHUNK bits per clock through one shared ripple
// segment. Optional magnitude mode re-runs the segment to form ~result+1
// when a subtraction borrows.
//   clk, rst : clock, synchronous active-high reset
//   io       : addsub_seq_if slave (operand and result handshakes)
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  addsub_seq_if.slave  io
);
  localparam int N    = nchunks(WIDTH, CHUNK);
  localparam int IDXW = idx_w(N);
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("addsub_seq: WIDTH must be a multiple of CHUNK");
  end

  state_t state, state_nxt;

  // Operands/result are held chunk-sliced so the active chunk is a plain index.
  logic [N-1:0][CHUNK-1:0] opa, opb, res, res_nxt;
  logic [IDXW-1:0]         idx;
  logic                    carry, sub_r, mag_r, cout_r, ovf_r, neg_r;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_co, ch_cmsb;
  logic             last, do_neg;

  chunk_addsub #(.CHUNK(CHUNK)) u_chunk (
    .x        (opa[idx]),
    .y        (opb[idx]),
    .cin      (carry),
    .sum      (ch_sum),
    .cout     (ch_co),
    .c_msb_in (ch_cmsb)
  );

  // Full result including the chunk being produced this cycle; NEG needs
  // the complete word on the final RUN chunk.
  always_comb begin
    res_nxt      = res;
    res_nxt[idx] = ch_sum;
  end

  assign last   = (idx == LAST);
  // On the final RUN chunk a missing carry-out is the subtraction borrow.
  assign do_neg = mag_r & sub_r & ~ch_co;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (io.in_valid)  state_nxt = RUN;
      RUN:  if (last)         state_nxt = do_neg ? NEG : DONE;
      NEG:  if (last)         state_nxt = DONE;
      DONE: if (io.out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    io.in_ready  = (state == IDLE);
    io.out_valid = (state == DONE);
    io.result    = res;
    io.cout      = cout_r;
    io.ovf       = ovf_r;
    io.neg       = neg_r;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      res    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      sub_r  <= 1'b0;
      mag_r  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          opa   <= io.a;
          opb   <= io.sub ? ~io.b : io.b;
          sub_r <= io.sub;
          mag_r <= io.mag;
          carry <= io.sub;   // +1 of the two's-complement negate
          idx   <= '0;
          neg_r <= 1'b0;
        end
        RUN: begin
          res   <= res_nxt;
          carry <= ch_co;
          idx   <= last ? '0 : idx + IDXW'(1);
          if (last) begin
            ovf_r  <= ch_cmsb ^ ch_co;
            cout_r <= ch_co ^ sub_r;
            if (do_neg) begin
              neg_r <= 1'b1;
              opa   <= ~res_nxt;
              opb   <= '0;
              carry <= 1'b1;
            end
          end
        end
        NEG: begin
          res   <= res_nxt;
          carry <= ch_co;
          idx   <= last ? '0 : idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
